// File: rtl/shift_add_mult.sv
// Sequential unsigned shift-add multiplier: one add/shift step per clock, WIDTH steps per operation.
// Start accepted at E0 -> done pulses after E(WIDTH+1); start is ignored while an operation is in flight.
module shift_add_mult #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_mcand;
  logic [WIDTH-1:0]     r_mplr;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_product;
  logic [CW-1:0]        r_cnt;
  logic                 r_busy;
  logic                 r_done;

  logic [WIDTH:0]       w_addend;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_acc_next;
  logic                 w_last;

  // The carry out of the upper-half add becomes the new MSB as the pair shifts right.
  always_comb begin
    w_addend   = r_mplr[0] ? {1'b0, r_mcand} : '0;
    w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + w_addend;
    w_acc_next = {w_sum, r_acc[WIDTH-1:1]};
  end

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  // busy/done are registered from the state, so they trail it by one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_mcand   <= '0;
      r_mplr    <= '0;
      r_acc     <= '0;
      r_product <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_busy <= (r_state == RUN);
      r_done <= (r_state == DONE);
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mcand <= multiplicand;
            r_mplr  <= multiplier;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_acc  <= w_acc_next;
          r_mplr <= r_mplr >> 1;
          r_cnt  <= r_cnt + CW'(1);
          if (w_last) begin
            r_product <= w_acc_next;
            r_state   <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign product = r_product;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule
